// File: rtl/imem_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arb_if
// Purpose  : IFU fetch, loader/debug and imem macro signals for imem_port_arb.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_port_arb_if #(
  parameter int AW     = 32,
  parameter int MEM_DP = 16384
);
  localparam int WIDX = $clog2(MEM_DP / 4);

  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [AW-1:0]   ifu_req_addr;
  logic            ifu_rsp_valid;
  logic [31:0]     ifu_rsp_data;
  logic            ifu_rsp_err;

  logic            ld_lock;
  logic            ld_req_valid;
  logic            ld_req_ready;
  logic            ld_req_we;
  logic [AW-1:0]   ld_req_addr;
  logic [31:0]     ld_req_wdata;
  logic [3:0]      ld_req_wstrb;
  logic            ld_rsp_valid;
  logic [31:0]     ld_rsp_rdata;
  logic            ld_rsp_err;

  logic            mem_cs;
  logic            mem_we;
  logic [WIDX-1:0] mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wstrb;
  logic [31:0]     mem_rdata;

  // Arbiter side
  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    input  ld_lock, ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata, ld_req_wstrb,
    output ld_req_ready, ld_rsp_valid, ld_rsp_rdata, ld_rsp_err,
    output mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  // Requester / memory-model side
  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    output ld_lock, ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata, ld_req_wstrb,
    input  ld_req_ready, ld_rsp_valid, ld_rsp_rdata, ld_rsp_err,
    input  mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arb
// Purpose  : Round-robin arbiter for the single-port imem between IFU and loader.
// Revision : 1.0 - initial release
// ============================================================================
module imem_port_arb #(
  parameter int AW     = 32,
  parameter int MEM_DP = 16384
) (
  input  wire logic      sys_clk,
  input  wire logic      sys_rst,
  imem_port_arb_if.slave bus
);
  localparam int            WIDX      = $clog2(MEM_DP / 4);
  localparam logic [AW-1:0] c_mem_lim = AW'(MEM_DP);

  logic          r_rr_last_ld;
  logic          r_ifu_rsp_valid;
  logic          r_ld_rsp_valid;
  logic          r_ifu_rsp_err;
  logic          r_ld_rsp_err;
  logic          r_rsp_rd;

  logic          w_ifu_elig;
  logic          w_ld_elig;
  logic          w_grant_ifu;
  logic          w_grant_ld;
  logic          w_grant;
  logic          w_err;
  logic          w_access;
  logic          w_write;
  logic [AW-1:0] w_addr;

  // Grants are held off while reset is asserted so every output reads 0 during reset.
  always_comb begin
    w_ifu_elig  = bus.ifu_req_valid & ~bus.ld_lock & ~sys_rst;
    w_ld_elig   = bus.ld_req_valid & ~sys_rst;
    w_grant_ifu = w_ifu_elig & (~w_ld_elig | r_rr_last_ld);
    w_grant_ld  = w_ld_elig & (~w_ifu_elig | ~r_rr_last_ld);
    w_grant     = w_grant_ifu | w_grant_ld;
    w_addr      = w_grant_ld ? bus.ld_req_addr : bus.ifu_req_addr;
    w_err       = (w_addr[1:0] != 2'b00) | (w_addr >= c_mem_lim);
    w_access    = w_grant & ~w_err;
    w_write     = w_access & w_grant_ld & bus.ld_req_we;
  end

  assign bus.ifu_req_ready = w_grant_ifu;
  assign bus.ld_req_ready  = w_grant_ld;

  assign bus.mem_cs    = w_access;
  assign bus.mem_we    = w_write;
  assign bus.mem_addr  = w_access ? w_addr[WIDX+1:2] : '0;
  assign bus.mem_wdata = w_write ? bus.ld_req_wdata : 32'h0;
  assign bus.mem_wstrb = w_write ? bus.ld_req_wstrb : (w_access ? 4'hF : 4'h0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rr_last_ld    <= 1'b1;
      r_ifu_rsp_valid <= 1'b0;
      r_ld_rsp_valid  <= 1'b0;
      r_ifu_rsp_err   <= 1'b0;
      r_ld_rsp_err    <= 1'b0;
      r_rsp_rd        <= 1'b0;
    end else begin
      r_ifu_rsp_valid <= w_grant_ifu;
      r_ld_rsp_valid  <= w_grant_ld;
      r_ifu_rsp_err   <= w_grant_ifu & w_err;
      r_ld_rsp_err    <= w_grant_ld & w_err;
      r_rsp_rd        <= w_access & ~w_write;
      if (w_grant) begin
        r_rr_last_ld <= w_grant_ld;
      end
    end
  end

  // Read data is forwarded straight from the macro, which answers one cycle after mem_cs.
  assign bus.ifu_rsp_valid = r_ifu_rsp_valid;
  assign bus.ifu_rsp_err   = r_ifu_rsp_err;
  assign bus.ifu_rsp_data  = (r_ifu_rsp_valid & r_rsp_rd) ? bus.mem_rdata : 32'h0;
  assign bus.ld_rsp_valid  = r_ld_rsp_valid;
  assign bus.ld_rsp_err    = r_ld_rsp_err;
  assign bus.ld_rsp_rdata  = (r_ld_rsp_valid & r_rsp_rd) ? bus.mem_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_port_arb
// Purpose  : Self-checking bench for imem_port_arb with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_port_arb;
  localparam int AW     = 32;
  localparam int MEM_DP = 16384;
  localparam int NWORDS = MEM_DP / 4;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  imem_port_arb_if #(.AW(AW), .MEM_DP(MEM_DP)) bus ();
  imem_port_arb #(.AW(AW), .MEM_DP(MEM_DP)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));

  // Memory macro: word i preloaded with value i, read data one cycle after the strobe.
  logic [31:0] macro_mem [NWORDS];
  bit          mem_inited = 1'b0;
  always @(posedge sys_clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < NWORDS; i++) macro_mem[i] <= 32'(i);
      mem_inited <= 1'b1;
    end else if (bus.mem_cs) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) macro_mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= macro_mem[bus.mem_addr];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected responses in grant order, last winner, shadow memory.
  typedef struct {
    bit          v;
    bit          is_ld;
    bit          err;
    logic [31:0] data;
  } rsp_t;
  rsp_t        rsp_q[$];
  bit          last_was_ld;
  logic [31:0] ref_mem [NWORDS];

  task automatic idle_inputs();
    bus.ifu_req_valid = 1'b0; bus.ifu_req_addr = '0;
    bus.ld_lock = 1'b0; bus.ld_req_valid = 1'b0; bus.ld_req_we = 1'b0;
    bus.ld_req_addr = '0; bus.ld_req_wdata = '0; bus.ld_req_wstrb = '0;
  endtask

  // One clock: check the response due now and this cycle's grant, then advance the model.
  task automatic step(output bit g_ifu, output bit g_ld);
    rsp_t r;
    bit ie, le, err, we;
    longint unsigned addr;
    @(negedge sys_clk);
    r = '{v: 1'b0, is_ld: 1'b0, err: 1'b0, data: 32'h0};
    if (rsp_q.size() > 0) r = rsp_q.pop_front();
    chk("ifu_rsp_valid", bus.ifu_rsp_valid, r.v && !r.is_ld);
    chk("ld_rsp_valid",  bus.ld_rsp_valid,  r.v && r.is_ld);
    chk("ifu_rsp_err",   bus.ifu_rsp_err,   r.v && !r.is_ld && r.err);
    chk("ld_rsp_err",    bus.ld_rsp_err,    r.v && r.is_ld && r.err);
    chk("ifu_rsp_data",  bus.ifu_rsp_data,  (r.v && !r.is_ld) ? r.data : 32'h0);
    chk("ld_rsp_rdata",  bus.ld_rsp_rdata,  (r.v && r.is_ld) ? r.data : 32'h0);

    ie = bus.ifu_req_valid && !bus.ld_lock;
    le = bus.ld_req_valid;
    if (ie && le) begin
      g_ifu = last_was_ld;
      g_ld  = !last_was_ld;
    end else begin
      g_ifu = ie;
      g_ld  = le;
    end
    chk("ifu_req_ready", bus.ifu_req_ready, g_ifu);
    chk("ld_req_ready",  bus.ld_req_ready,  g_ld);
    addr = g_ld ? longint'(bus.ld_req_addr) : longint'(bus.ifu_req_addr);
    err  = (addr % 4 != 0) || (addr >= MEM_DP);
    chk("mem_cs", bus.mem_cs, (g_ifu || g_ld) && !err);
    if (g_ifu || g_ld) begin
      we = g_ld && bus.ld_req_we;
      chk("mem_we", bus.mem_we, !err && we);
      r = '{v: 1'b1, is_ld: g_ld, err: err, data: 32'h0};
      if (!err && !we) r.data = ref_mem[addr / 4];
      if (!err && we)
        for (int b = 0; b < 4; b++)
          if (bus.ld_req_wstrb[b]) ref_mem[addr / 4][8*b +: 8] = bus.ld_req_wdata[8*b +: 8];
      rsp_q.push_back(r);
      last_was_ld = g_ld;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    idle_inputs();
    rsp_q.delete();
    last_was_ld = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 99);
    if (r < 5)  return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    if (r < 8)  return 32'(MEM_DP + $urandom_range(0, 255) * 4);
    if (r < 10) return 32'(MEM_DP - 4);
    return 32'($urandom_range(0, 63) * 4);
  endfunction

  typedef struct {
    bit          iv, lv, lock, we;
    logic [31:0] ia, la, wd;
    logic [3:0]  ws;
    bit          e_irdy, e_lrdy, e_cs;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gi, gl;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = 32'(i);

    // Contention alternation, plain IFU stream, error and boundary addresses.
    tbl.push_back('{1,1,0,0, 32'h20, 32'h24, 0, 0, 1,0,1});
    tbl.push_back('{1,1,0,0, 32'h28, 32'h24, 0, 0, 0,1,1});
    tbl.push_back('{1,1,0,0, 32'h28, 32'h2C, 0, 0, 1,0,1});
    tbl.push_back('{1,1,0,0, 32'h30, 32'h2C, 0, 0, 0,1,1});
    tbl.push_back('{1,0,0,0, 32'h0,  32'h0,  0, 0, 1,0,1});
    tbl.push_back('{1,0,0,0, 32'h4,  32'h0,  0, 0, 1,0,1});
    tbl.push_back('{1,0,0,0, 32'h8,  32'h0,  0, 0, 1,0,1});
    tbl.push_back('{1,0,0,0, 32'h2,  32'h0,  0, 0, 1,0,0});
    tbl.push_back('{0,1,0,0, 32'h0,  32'(MEM_DP),   0, 0, 0,1,0});
    tbl.push_back('{0,1,0,0, 32'h0,  32'(MEM_DP-4), 0, 0, 0,1,1});
    tbl.push_back('{0,0,0,0, 32'h0,  32'h0,  0, 0, 0,0,0});

    apply_reset();
    chk("reset_ifu_rsp_valid", bus.ifu_rsp_valid, 1'b0);
    chk("reset_ld_rsp_valid",  bus.ld_rsp_valid,  1'b0);
    chk("reset_mem_cs",        bus.mem_cs,        1'b0);
    step(gi, gl);

    foreach (tbl[k]) begin
      bus.ifu_req_valid = tbl[k].iv; bus.ifu_req_addr = tbl[k].ia;
      bus.ld_lock = tbl[k].lock; bus.ld_req_valid = tbl[k].lv; bus.ld_req_we = tbl[k].we;
      bus.ld_req_addr = tbl[k].la; bus.ld_req_wdata = tbl[k].wd; bus.ld_req_wstrb = tbl[k].ws;
      #1;
      chk($sformatf("vec%0d_ifu_ready", k), bus.ifu_req_ready, tbl[k].e_irdy);
      chk($sformatf("vec%0d_ld_ready", k),  bus.ld_req_ready,  tbl[k].e_lrdy);
      chk($sformatf("vec%0d_mem_cs", k),    bus.mem_cs,        tbl[k].e_cs);
      step(gi, gl);
    end

    // IFU fetch in flight when the loader takes the lock, then partial write and readback.
    idle_inputs();
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h40;
    step(gi, gl);
    bus.ifu_req_addr = 32'h44; bus.ld_lock = 1'b1;
    bus.ld_req_valid = 1'b1; bus.ld_req_we = 1'b1; bus.ld_req_addr = 32'h10;
    bus.ld_req_wdata = 32'h0; bus.ld_req_wstrb = 4'hF;
    step(gi, gl);
    bus.ld_req_wdata = 32'hDEADBEEF; bus.ld_req_wstrb = 4'h3;
    #1 chk("lock_ifu_ready", bus.ifu_req_ready, 1'b0);
    step(gi, gl);
    bus.ld_req_we = 1'b0; bus.ld_req_wdata = 32'h0; bus.ld_req_wstrb = 4'h0;
    step(gi, gl);
    #1;
    chk("readback_valid", bus.ld_rsp_valid, 1'b1);
    chk("readback_data",  bus.ld_rsp_rdata, 32'h0000BEEF);
    bus.ld_req_valid = 1'b0; bus.ld_lock = 1'b0;
    step(gi, gl);
    bus.ifu_req_valid = 1'b0;
    step(gi, gl);

    // Reset the cycle after a grant: the pending response must vanish.
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8;
    step(gi, gl);
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'hC;
    sys_rst = 1'b1;
    #1;
    chk("rst_ifu_rsp_valid", bus.ifu_rsp_valid, 1'b0);
    chk("rst_ld_rsp_valid",  bus.ld_rsp_valid,  1'b0);
    chk("rst_ifu_ready",     bus.ifu_req_ready, 1'b0);
    chk("rst_ld_ready",      bus.ld_req_ready,  1'b0);
    chk("rst_mem_cs",        bus.mem_cs,        1'b0);
    chk("rst_ifu_rsp_data",  bus.ifu_rsp_data,  32'h0);
    apply_reset();
    repeat (3) step(gi, gl);

    // Randomised traffic; requests are held until the model says they were accepted.
    gi = 1'b0; gl = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!bus.ifu_req_valid || gi) begin
        bus.ifu_req_valid = ($urandom_range(0, 99) < 70);
        bus.ifu_req_addr  = rand_addr();
      end
      if (!bus.ld_req_valid || gl) begin
        bus.ld_req_valid = ($urandom_range(0, 99) < 50);
        bus.ld_req_addr  = rand_addr();
        bus.ld_req_we    = $urandom_range(0, 1) == 1;
        bus.ld_req_wdata = $urandom;
        bus.ld_req_wstrb = 4'($urandom_range(0, 15));
      end
      bus.ld_lock = ($urandom_range(0, 99) < 15);
      step(gi, gl);
    end
    idle_inputs();
    repeat (2) step(gi, gl);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
